// File: rtl/board_figure_mem_pkg.sv
// -----------------------------------------------------------------------------
// board_figure_mem_pkg
// Shared definitions for the board-state store: piece-code constants, command
// opcodes, FSM state encoding and the start-layout function used by both the
// reset path and the INIT command.
// -----------------------------------------------------------------------------
package board_figure_mem_pkg;

   localparam int SQUARES = 64;
   localparam int CODE_W  = 4;
   localparam int LINES   = 32;

   // Piece codes: bit 3 selects black, bits 2:0 select the piece type.
   localparam logic [CODE_W-1:0] PC_EMPTY  = 4'd0;
   localparam logic [CODE_W-1:0] PC_PAWN   = 4'd1;
   localparam logic [CODE_W-1:0] PC_KNIGHT = 4'd2;
   localparam logic [CODE_W-1:0] PC_BISHOP = 4'd3;
   localparam logic [CODE_W-1:0] PC_ROOK   = 4'd4;
   localparam logic [CODE_W-1:0] PC_QUEEN  = 4'd5;
   localparam logic [CODE_W-1:0] PC_KING   = 4'd6;
   localparam logic [CODE_W-1:0] PC_BLACK  = 4'd8;

   typedef enum logic [1:0] {
      OP_MOVE = 2'b00,
      OP_SET  = 2'b01,
      OP_INIT = 2'b10,
      OP_RSVD = 2'b11
   } cmd_op_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHK    = 3'd1,
      ST_WR_DST = 3'd2,
      ST_WR_SRC = 3'd3,
      ST_INIT   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Start layout: square index = row*8 + column, row 0 (black side) on top.
   function automatic logic [CODE_W-1:0] INIT_LAYOUT(input logic [5:0] sq);
      logic [CODE_W-1:0] back;
      logic [CODE_W-1:0] code;
      case (sq[2:0])
         3'd0, 3'd7: back = PC_ROOK;
         3'd1, 3'd6: back = PC_KNIGHT;
         3'd2, 3'd5: back = PC_BISHOP;
         3'd3:       back = PC_QUEEN;
         default:    back = PC_KING;
      endcase
      case (sq[5:3])
         3'd0:    code = PC_BLACK | back;
         3'd1:    code = PC_BLACK | PC_PAWN;
         3'd6:    code = PC_PAWN;
         3'd7:    code = back;
         default: code = PC_EMPTY;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/board_figure_mem_if.sv
// -----------------------------------------------------------------------------
// board_figure_mem_if
// Bundles the display read port and the board-update command port.
//   Display: figure_xy/figure_line in, figure_pixels out (2-cycle latency).
//   Command: cmd_valid/cmd_ready handshake with cmd_op/src/dst/code payload;
//            done/err/captured report completion.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while the store is idle, and
// cmd_valid seen while cmd_ready is low is dropped, never queued.
// -----------------------------------------------------------------------------
interface board_figure_mem_if;
   import board_figure_mem_pkg::*;

   logic [7:0]  figure_xy;
   logic [4:0]  figure_line;
   logic [63:0] figure_pixels;

   logic        cmd_valid;
   logic        cmd_ready;
   cmd_op_t     cmd_op;
   logic [5:0]  cmd_src;
   logic [5:0]  cmd_dst;
   logic [3:0]  cmd_code;

   logic        done;
   logic        err;
   logic [3:0]  captured;

   modport master (
      output figure_xy, figure_line, cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_code,
      input  figure_pixels, cmd_ready, done, err, captured
   );

   modport slave (
      input  figure_xy, figure_line, cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_code,
      output figure_pixels, cmd_ready, done, err, captured
   );

endinterface

// File: rtl/board_figure_mem_figure_rom.sv
// -----------------------------------------------------------------------------
// figure_rom
// Registered glyph ROM: (piece code, glyph line) -> 64-bit line of 32 two-bit
// pixels, MSB first. Each piece type has a 16-bit silhouette per band of 8
// lines; every silhouette bit covers two adjacent pixels. Silhouette pixels use
// white (10) or black (11) by the colour bit; everything else is transparent.
// Codes with type 0 or 7 produce an all-transparent line.
//   clk, rst   : clock, asynchronous active-high reset (output cleared)
//   code_i     : piece code
//   line_i     : glyph line 0..31
//   pixels_o   : registered glyph line
// -----------------------------------------------------------------------------
module figure_rom
   import board_figure_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] code_i,
   input  logic [4:0]        line_i,
   output logic [63:0]       pixels_o
);

   logic [15:0] mask;
   logic [1:0]  col;
   logic [63:0] pixels_d;
   logic [63:0] pixels_q;

   always_comb begin
      mask = 16'h0000;
      case ({code_i[2:0], line_i[4:3]})
         5'b001_00: mask = 16'h0000;  // pawn
         5'b001_01: mask = 16'h03C0;
         5'b001_10: mask = 16'h07E0;
         5'b001_11: mask = 16'h1FF8;
         5'b010_00: mask = 16'h07C0;  // knight
         5'b010_01: mask = 16'h0FF0;
         5'b010_10: mask = 16'h03E0;
         5'b010_11: mask = 16'h1FF8;
         5'b011_00: mask = 16'h0180;  // bishop
         5'b011_01: mask = 16'h03C0;
         5'b011_10: mask = 16'h07E0;
         5'b011_11: mask = 16'h1FF8;
         5'b100_00: mask = 16'h1998;  // rook
         5'b100_01: mask = 16'h0FF0;
         5'b100_10: mask = 16'h0FF0;
         5'b100_11: mask = 16'h3FFC;
         5'b101_00: mask = 16'h2A54;  // queen
         5'b101_01: mask = 16'h1FF8;
         5'b101_10: mask = 16'h0FF0;
         5'b101_11: mask = 16'h3FFC;
         5'b110_00: mask = 16'h0180;  // king
         5'b110_01: mask = 16'h07E0;
         5'b110_10: mask = 16'h0FF0;
         5'b110_11: mask = 16'h3FFC;
         default:   mask = 16'h0000;
      endcase

      col      = code_i[3] ? 2'b11 : 2'b10;
      pixels_d = 64'd0;
      // Mask bit 15-k drives pixels 2k and 2k+1 (4 bits from the MSB end).
      for (int k = 0; k < 16; k++) begin
         if (mask[15-k]) pixels_d[63-4*k -: 4] = {col, col};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pixels_q <= 64'd0;
      else     pixels_q <= pixels_d;
   end

   assign pixels_o = pixels_q;

endmodule

// File: rtl/board_figure_mem.sv
// -----------------------------------------------------------------------------
// board_figure_mem
// Holds the piece code of all 64 squares and serves draw_figure's per-pixel
// glyph reads, while an FSM applies MOVE / SET / INIT board updates.
//   clk, rst    : pixel clock, asynchronous active-high reset (start layout)
//   bus         : slave side of board_figure_mem_if (display + command ports)
//   dbg_state_o : current FSM state
// -----------------------------------------------------------------------------
module board_figure_mem
   import board_figure_mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   board_figure_mem_if.slave   bus,
   output state_t              dbg_state_o
);

   state_t                          state_q, state_d;
   cmd_op_t                         op_q, op_d;
   logic [5:0]                      src_q, src_d;
   logic [5:0]                      dst_q, dst_d;
   logic [CODE_W-1:0]               code_q, code_d;
   logic [5:0]                      cnt_q, cnt_d;
   logic [CODE_W-1:0]               captured_q, captured_d;
   logic                            err_q, err_d;
   logic [SQUARES-1:0][CODE_W-1:0]  board_q;
   logic [CODE_W-1:0]               disp_code_q;
   logic [4:0]                      disp_line_q;

   logic                            wr_en;
   logic [5:0]                      wr_addr;
   logic [CODE_W-1:0]               wr_data;
   logic                            done;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      src_d      = src_q;
      dst_d      = dst_q;
      code_d     = code_q;
      cnt_d      = cnt_q;
      captured_d = captured_q;
      err_d      = err_q;
      wr_en      = 1'b0;
      wr_addr    = dst_q;
      wr_data    = code_q;
      done       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               op_d   = bus.cmd_op;
               src_d  = bus.cmd_src;
               dst_d  = bus.cmd_dst;
               code_d = bus.cmd_code;
               cnt_d  = 6'd0;
               err_d  = 1'b0;
               case (bus.cmd_op)
                  OP_MOVE: state_d = ST_CHK;
                  OP_SET:  state_d = ST_WR_DST;
                  OP_INIT: begin
                     captured_d = PC_EMPTY;
                     state_d    = ST_INIT;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_DONE;
                  end
               endcase
            end
         end
         ST_CHK: begin
            if (board_q[src_q] == PC_EMPTY) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               captured_d = board_q[dst_q];
               state_d    = ST_WR_DST;
            end
         end
         ST_WR_DST: begin
            wr_en   = 1'b1;
            wr_addr = dst_q;
            if (op_q == OP_MOVE) begin
               wr_data = board_q[src_q];
               state_d = ST_WR_SRC;
            end else begin
               wr_data    = code_q;
               captured_d = board_q[dst_q];
               state_d    = ST_DONE;
            end
         end
         ST_WR_SRC: begin
            // src == dst already holds the moved piece; clearing it would erase it.
            wr_en   = (src_q != dst_q);
            wr_addr = src_q;
            wr_data = PC_EMPTY;
            state_d = ST_DONE;
         end
         ST_INIT: begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = INIT_LAYOUT(cnt_q);
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'd63) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_MOVE;
         src_q       <= 6'd0;
         dst_q       <= 6'd0;
         code_q      <= PC_EMPTY;
         cnt_q       <= 6'd0;
         captured_q  <= PC_EMPTY;
         err_q       <= 1'b0;
         disp_code_q <= PC_EMPTY;
         disp_line_q <= 5'd0;
         for (int i = 0; i < SQUARES; i++) board_q[i] <= INIT_LAYOUT(6'(i));
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         code_q     <= code_d;
         cnt_q      <= cnt_d;
         captured_q <= captured_d;
         err_q      <= err_d;
         if (wr_en) board_q[wr_addr] <= wr_data;
         // Display stage 1 samples the pre-write board (read-before-write).
         disp_code_q <= (bus.figure_xy >= 8'd64) ? PC_EMPTY : board_q[bus.figure_xy[5:0]];
         disp_line_q <= bus.figure_line;
      end
   end

   figure_rom u_figure_rom (
      .clk      (clk),
      .rst      (rst),
      .code_i   (disp_code_q),
      .line_i   (disp_line_q),
      .pixels_o (bus.figure_pixels)
   );

   // The state register idles during reset, so rst masks ready explicitly.
   assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
   assign bus.done      = done;
   assign bus.err       = done && err_q;
   assign bus.captured  = captured_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_board_figure_mem.sv
// -----------------------------------------------------------------------------
// tb_board_figure_mem
// Directed plus randomized stimulus for board_figure_mem, checked against a
// behavioural board model and an independent glyph table.
// -----------------------------------------------------------------------------
module tb_board_figure_mem;
   import board_figure_mem_pkg::*;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;

   always #5 clk = ~clk;

   board_figure_mem_if bus ();

   board_figure_mem dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- reference model ----------------
   int          passed = 0;
   int          total  = 0;
   int          fails  = 0;
   logic [3:0]  model [64];
   logic [3:0]  cap_model = 4'd0;

   // Silhouette per (type*4 + band); band = line/8, bit 15 = leftmost pixel pair.
   logic [15:0] gm [28] = '{
      16'h0000, 16'h0000, 16'h0000, 16'h0000,
      16'h0000, 16'h03C0, 16'h07E0, 16'h1FF8,
      16'h07C0, 16'h0FF0, 16'h03E0, 16'h1FF8,
      16'h0180, 16'h03C0, 16'h07E0, 16'h1FF8,
      16'h1998, 16'h0FF0, 16'h0FF0, 16'h3FFC,
      16'h2A54, 16'h1FF8, 16'h0FF0, 16'h3FFC,
      16'h0180, 16'h07E0, 16'h0FF0, 16'h3FFC
   };

   int back_rank [8] = '{4, 2, 3, 5, 6, 3, 2, 4};

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         int row, cl;
         row = i / 8;
         cl  = i % 8;
         if (row == 0)      model[i] = 4'(8 + back_rank[cl]);
         else if (row == 1) model[i] = 4'd9;
         else if (row == 6) model[i] = 4'd1;
         else if (row == 7) model[i] = 4'(back_rank[cl]);
         else               model[i] = 4'd0;
      end
   endtask

   function automatic logic [63:0] exp_pix(input logic [3:0] code, input int line);
      logic [63:0] p;
      logic [15:0] m;
      int          t;
      p = 64'd0;
      t = int'(code) % 8;
      if (t == 0 || t == 7) return p;
      m = gm[t*4 + line/8];
      for (int px = 0; px < 32; px++) begin
         if (m[15 - px/2]) p[63-2*px -: 2] = code[3] ? 2'b11 : 2'b10;
      end
      return p;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic rd(input int xy, input int line, output logic [63:0] pix);
      bus.figure_xy   = 8'(xy);
      bus.figure_line = 5'(line);
      @(posedge clk);
      @(posedge clk);
      #1 pix = bus.figure_pixels;
      @(negedge clk);
   endtask

   task automatic chk_sq(input string tag, input int sq);
      logic [63:0] pix;
      int          line;
      line = $urandom_range(0, 31);
      rd(sq, line, pix);
      chk(tag, pix, exp_pix(model[sq], line));
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [5:0] src, input logic [5:0] dst,
                         input logic [3:0] code, output int lat, output logic e,
                         output logic [3:0] cap);
      int w;
      w = 0;
      while (bus.cmd_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      bus.cmd_op    = cmd_op_t'(op);
      bus.cmd_src   = src;
      bus.cmd_dst   = dst;
      bus.cmd_code  = code;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      lat = 0;
      e   = 1'bx;
      cap = 4'bx;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (bus.done === 1'b1) begin
            e   = bus.err;
            cap = bus.captured;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int          lat;
      logic        e;
      logic [3:0]  cap;
      logic [63:0] pix;
      int          rdy_hi;
      int          done_cnt;

      bus.figure_xy   = 8'd0;
      bus.figure_line = 5'd0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_op      = OP_MOVE;
      bus.cmd_src     = 6'd0;
      bus.cmd_dst     = 6'd0;
      bus.cmd_code    = 4'd0;
      model_reset();

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pixels",   bus.figure_pixels, 64'd0);
      chk("rst_ready",    64'(bus.cmd_ready), 64'd0);
      chk("rst_done",     64'(bus.done), 64'd0);
      chk("rst_err",      64'(bus.err), 64'd0);
      chk("rst_captured", 64'(bus.captured), 64'd0);
      rst = 1'b0;
      #1 chk("ready_after_rst", 64'(bus.cmd_ready), 64'd1);
      chk("idle_after_rst", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clk);

      // Display of the start layout
      rd(0, 10, pix);
      chk("disp_sq0_l10", pix, exp_pix(4'hC, 10));
      rd(30, 5, pix);
      chk("disp_sq30", pix, 64'd0);

      // MOVE 52 -> 36
      do_cmd(OP_MOVE, 6'd52, 6'd36, 4'd0, lat, e, cap);
      chk("move_lat", 64'(lat), 64'd4);
      chk("move_err", 64'(e), 64'd0);
      chk("move_cap", 64'(cap), 64'(model[36]));
      cap_model = model[36];
      model[36] = model[52];
      model[52] = 4'd0;
      chk_sq("move_sq36", 36);
      chk_sq("move_sq52", 52);

      // MOVE from empty square
      do_cmd(OP_MOVE, 6'd20, 6'd28, 4'd0, lat, e, cap);
      chk("empty_lat", 64'(lat), 64'd2);
      chk("empty_err", 64'(e), 64'd1);
      chk_sq("empty_sq20", 20);
      chk_sq("empty_sq28", 28);

      // SET 8 <- queen, then MOVE 8 -> 8
      do_cmd(OP_SET, 6'd0, 6'd8, 4'd5, lat, e, cap);
      chk("set_lat", 64'(lat), 64'd2);
      chk("set_err", 64'(e), 64'd0);
      chk("set_cap", 64'(cap), 64'd9);
      model[8] = 4'd5;
      chk_sq("set_sq8", 8);
      do_cmd(OP_MOVE, 6'd8, 6'd8, 4'd0, lat, e, cap);
      chk("self_lat", 64'(lat), 64'd4);
      chk("self_err", 64'(e), 64'd0);
      chk("self_cap", 64'(cap), 64'd5);
      cap_model = 4'd5;
      chk_sq("self_sq8", 8);

      // Reserved opcode
      do_cmd(OP_RSVD, 6'd1, 6'd2, 4'd3, lat, e, cap);
      chk("rsvd_lat", 64'(lat), 64'd1);
      chk("rsvd_err", 64'(e), 64'd1);
      chk_sq("rsvd_sq2", 2);

      // Randomized MOVE / SET traffic
      for (int n = 0; n < 24; n++) begin
         logic [5:0] s, d;
         logic [3:0] c;
         int         exp_lat;
         logic       exp_err;
         logic [3:0] exp_cap;
         d = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 9) < 6) begin
            s = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0) begin
               for (int t = 0; t < 64 && model[s] == 4'd0; t++) s = 6'($urandom_range(0, 63));
            end
            if (model[s] == 4'd0) begin
               exp_lat = 2;
               exp_err = 1'b1;
               exp_cap = cap_model;
            end else begin
               exp_lat  = 4;
               exp_err  = 1'b0;
               exp_cap  = model[d];
               model[d] = model[s];
               if (s != d) model[s] = 4'd0;
            end
            do_cmd(OP_MOVE, s, d, 4'd0, lat, e, cap);
            chk("rnd_move_lat", 64'(lat), 64'(exp_lat));
            chk("rnd_move_err", 64'(e), 64'(exp_err));
            if (!exp_err) chk("rnd_move_cap", 64'(cap), 64'(exp_cap));
            chk_sq("rnd_move_dst", int'(d));
            chk_sq("rnd_move_src", int'(s));
         end else begin
            c        = 4'($urandom_range(0, 15));
            exp_cap  = model[d];
            model[d] = c;
            do_cmd(OP_SET, 6'($urandom_range(0, 63)), d, c, lat, e, cap);
            chk("rnd_set_lat", 64'(lat), 64'd2);
            chk("rnd_set_err", 64'(e), 64'd0);
            chk("rnd_set_cap", 64'(cap), 64'(exp_cap));
            chk_sq("rnd_set_dst", int'(d));
         end
         if (!exp_err) cap_model = exp_cap;
         rd($urandom_range(64, 255), $urandom_range(0, 31), pix);
         chk("rnd_offboard", pix, 64'd0);
      end

      // INIT with a SET request held during the busy period (must be dropped)
      while (bus.cmd_ready !== 1'b1) @(negedge clk);
      bus.cmd_op    = OP_INIT;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_op   = OP_SET;
      bus.cmd_dst  = 6'd0;
      bus.cmd_code = 4'd1;
      lat    = 0;
      rdy_hi = 0;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == 30) bus.cmd_valid = 1'b0;
         if (bus.cmd_ready === 1'b1) rdy_hi++;
         if (bus.done === 1'b1) begin
            e   = bus.err;
            cap = bus.captured;
            break;
         end
      end
      chk("init_lat", 64'(lat), 64'd65);
      chk("init_err", 64'(e), 64'd0);
      chk("init_cap", 64'(cap), 64'd0);
      chk("init_busy_ready", 64'(rdy_hi), 64'd0);
      @(negedge clk);
      model_reset();
      for (int sq = 0; sq < 64; sq++) chk_sq("init_board", sq);

      // Reset during WR_SRC of a MOVE
      rd(0, 20, pix);
      while (bus.cmd_ready !== 1'b1) @(negedge clk);
      bus.cmd_op    = OP_MOVE;
      bus.cmd_src   = 6'd49;
      bus.cmd_dst   = 6'd41;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_state", 64'(dbg_state), 64'(ST_WR_SRC));
      rst = 1'b1;
      #1;
      chk("abort_done",   64'(bus.done), 64'd0);
      chk("abort_ready",  64'(bus.cmd_ready), 64'd0);
      chk("abort_err",    64'(bus.err), 64'd0);
      chk("abort_cap",    64'(bus.captured), 64'd0);
      chk("abort_pixels", bus.figure_pixels, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      model_reset();
      for (int sq = 0; sq < 64; sq++) chk_sq("abort_board", sq);
      rd(70, 12, pix);
      chk("offboard_70", pix, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
